sevenseg_scan: RTL and testbench
================================

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 Parameter: DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 clk  input  1  rising-edge system clock; only clock in the block.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sum  input  4  adder sum bits, sampled only on an accepted load.
REQ-005 cout  input  1  adder carry-out, sampled with sum; value = {cout,sum}, range 0..31.
REQ-006 load  input  1  request to convert and display the current {cout,sum}.
REQ-007 busy  output  1  high while a conversion is in progress; load is ignored while high.
REQ-008 done  output  1  single-cycle pulse when new digits become displayed.
REQ-009 seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-010 an  output  2  active-low digit enables: an[0] is the ones digit, an[1] the tens digit; registered.

Function
REQ-011 FSM states SHALL be IDLE, CONV and DONE; reset state SHALL be IDLE.
REQ-012 IDLE: load=1 at edge N SHALL latch {cout,sum}, enter CONV and raise busy from cycle N+1.
REQ-013 CONV SHALL run sequential double-dabble for exactly 5 cycles (one shift per bit, add-3 on nibbles >=5 before each shift), then enter DONE.
REQ-014 DONE SHALL copy the converted tens/ones BCD into the display registers, pulse done=1 for one cycle and return to IDLE; busy SHALL be low in DONE.
REQ-015 Latency: load accepted at edge N -> busy high for cycles N+1..N+5, done high at N+6, new digits visible from the next slot boundary at or after N+6.
REQ-016 The display registers SHALL hold the previous digits, unchanged, throughout CONV; the update SHALL be atomic.
REQ-017 load asserted while busy=1 SHALL be dropped (not queued); load held high in IDLE SHALL start back-to-back conversions.
REQ-018 The divider SHALL count 0..DIV-1; on wrap the digit select SHALL toggle ones->tens->ones; an/seg SHALL change on the same edge.
REQ-019 The tens digit SHALL be 0..3 and the ones digit 0..9; the decode SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Exactly one of an[1:0] SHALL be low at any time after the first slot, except when the tens slot is blanked (REQ-025).

Reset
REQ-021 rst=1 SHALL force: FSM=IDLE, busy=0, done=0, divider=0, digit select=ones, display digits=0, seg=7'b1111111, an=2'b11.
REQ-022 Reset asserted mid-CONV SHALL abort the conversion with no done pulse; the display SHALL show 0.
REQ-023 The first edge after rst deasserts SHALL drive an=2'b10 with the ones digit's segments.

Configuration
REQ-024 Macro SEVENSEG_BLANK_LEADING_ZERO_EN SHALL select leading-zero blanking.
REQ-025 Macro defined: during the tens slot with tens=0, an SHALL be 2'b11 and seg SHALL be 7'b1111111; slot timing is unchanged.
REQ-026 Macro undefined: the tens digit 0 SHALL be displayed as 1000000 with an=2'b01.

Structure
REQ-027 Package sevenseg_pkg SHALL hold the FSM state enum, the ten segment constants, SEG_BLANK and the DIV default.
REQ-028 Sub-module seg_decode (4-bit BCD -> 7-bit active-low pattern, combinational) SHALL be instantiated once on the selected digit.

Verification (DIV=4)
REQ-029 Reset: hold rst for 3 cycles -> seg=1111111, an=11, busy=0, done=0; the next edge gives an=10, seg=1000000.
REQ-030 sum=1001, cout=0, load 1 cycle -> busy for 5 cycles, done pulse at N+6; ones slot seg=0010000, tens slot seg=1000000 (macro off) or an=11 (macro on).
REQ-031 sum=1111, cout=1 (31) -> tens slot an=01, seg=0110000; ones slot an=10, seg=1111001.
REQ-032 Load 31, then load 5 on cycle N+2 -> the second load is ignored; the display shows 31 and exactly one done pulse occurs.
REQ-033 Load 16, then rst at N+3 -> no done pulse; the display shows 0; a subsequent load of 16 shows tens=1 (1111001) and ones=6 (0000010).
REQ-034 Free run for 40 cycles -> an toggles every 4 cycles and is never 00.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner.
// Leading-zero blanking is selected with SEVENSEG_BLANK_LEADING_ZERO_EN.
package sevenseg_pkg;

    localparam int DIV_DEFAULT = 50000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Active-low patterns ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Codes above 9 decode to a blank digit.
module seg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Converts a 5-bit adder result to two BCD digits and time-multiplexes them on a display.
// Define SEVENSEG_BLANK_LEADING_ZERO_EN to blank a zero tens digit.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sum,
    input  logic       cout,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [1:0] an,
    output state_e     dbg_state
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    // Handshake: load is accepted only in IDLE (busy low); a load seen while
    // busy is dropped. done pulses for one cycle when the new digits are latched.
    state_e        state_q, state_d;
    logic [12:0]   shift_q, shift_d;     // {tens, ones, binary} double-dabble register
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [DW-1:0] div_q, div_d;
    logic          sel_q, sel_d;         // 0 = ones slot, 1 = tens slot
    logic          live_q, live_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic [3:0]    tens_adj, ones_adj;
    logic [3:0]    digit;
    logic [6:0]    dec_seg;
    logic          refresh;
    logic          blank;

    seg_decode u_seg_decode (
        .bcd (digit),
        .seg (dec_seg)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        div_d     = div_q;
        sel_d     = sel_q;
        live_d    = 1'b1;
        seg_d     = seg_q;
        an_d      = an_q;
        refresh   = 1'b0;
        blank     = 1'b0;

        tens_adj = (shift_q[12:9] >= 4'd5) ? shift_q[12:9] + 4'd3 : shift_q[12:9];
        ones_adj = (shift_q[8:5] >= 4'd5) ? shift_q[8:5] + 4'd3 : shift_q[8:5];

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d   = {8'd0, cout, sum};
                    bit_cnt_d = 3'd0;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                shift_d   = {tens_adj[2:0], ones_adj, shift_q[4:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd4) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tens_d  = shift_q[10:9];
                ones_d  = shift_q[8:5];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (live_q) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                sel_d   = ~sel_q;
                refresh = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end else begin
            // First edge out of reset lights the ones digit immediately.
            refresh = 1'b1;
        end

        // Digits come from the _d values so a copy landing on a slot edge shows at once.
        digit = sel_d ? {2'b00, tens_d} : ones_d;
`ifdef SEVENSEG_BLANK_LEADING_ZERO_EN
        blank = sel_d && (tens_d == 2'd0);
`else
        blank = 1'b0;
`endif

        if (refresh) begin
            seg_d = blank ? SEG_BLANK : dec_seg;
            an_d  = blank ? AN_OFF : (sel_d ? AN_TENS : AN_ONES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            div_q     <= '0;
            sel_q     <= 1'b0;
            live_q    <= 1'b0;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            div_q     <= div_d;
            sel_q     <= sel_d;
            live_q    <= live_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign busy      = (state_q == S_CONV);
    assign done      = (state_q == S_DONE);
    assign seg       = seg_q;
    assign an        = an_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed and randomized checks of sevenseg_scan with DIV=4 against a decimal reference model.
// Honours SEVENSEG_BLANK_LEADING_ZERO_EN when computing the expected tens slot.
module tb_sevenseg_scan;
    import sevenseg_pkg::*;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       cout = 1'b0;
    logic [3:0] sum = 4'd0;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [1:0] an;
    state_e     dbg_state;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    sevenseg_scan #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .sum       (sum),
        .cout      (cout),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .seg       (seg),
        .an        (an),
        .dbg_state (dbg_state)
    );

    function automatic logic [6:0] pat(input int d);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input int v);
        @(negedge clk);
        {cout, sum} = 5'(v);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Accepted at edge N: busy for 5 cycles, then a single done cycle.
    task automatic load_and_check(input int v);
        drive_load(v);
        chk("busy_n0", 8'(busy), 8'd1);
        chk("done_n0", 8'(done), 8'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("busy_conv", 8'(busy), 8'd1);
            chk("done_conv", 8'(done), 8'd0);
        end
        tick();
        chk("busy_done", 8'(busy), 8'd0);
        chk("done_pulse", 8'(done), 8'd1);
        tick();
        chk("done_drop", 8'(done), 8'd0);
    endtask

    // Over two full slots every cycle must show one of the two expected digits, four cycles each.
    task automatic check_display(input int v);
        int ones_hits;
        int tens_hits;
        logic [1:0] tens_an;
        logic [6:0] tens_seg;
        ones_hits = 0;
        tens_hits = 0;
        tens_an = 2'b01;
        tens_seg = pat(v / 10);
`ifdef SEVENSEG_BLANK_LEADING_ZERO_EN
        if (v / 10 == 0) begin
            tens_an = 2'b11;
            tens_seg = 7'b1111111;
        end
`endif
        repeat (2 * DIV) tick();
        for (int i = 0; i < 2 * DIV; i++) begin
            chk("an_not_00", 8'(an == 2'b00), 8'd0);
            if (an === 2'b10 && seg === pat(v % 10)) ones_hits++;
            else if (an === tens_an && seg === tens_seg) tens_hits++;
            tick();
        end
        chk("ones_slot", 8'(ones_hits), 8'(DIV));
        chk("tens_slot", 8'(tens_hits), 8'(DIV));
    endtask

    initial begin
        int base;
        int v;
        int run;
        logic [1:0] prev_an;
        logic seen_change;

        // Reset held for three cycles
        repeat (3) tick();
        chk("rst_seg", 8'(seg), 8'(7'b1111111));
        chk("rst_an", 8'(an), 8'(2'b11));
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_state", 8'(dbg_state), 8'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("first_an", 8'(an), 8'(2'b10));
        chk("first_seg", 8'(seg), 8'(7'b1000000));

        load_and_check(9);
        check_display(9);
        load_and_check(31);
        check_display(31);

        // Second load while busy is dropped
        base = done_cnt;
        drive_load(31);
        tick();
        @(negedge clk);
        {cout, sum} = 5'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("busy_ignore", 8'(busy), 8'd1);
        repeat (10) tick();
        chk("one_done", 8'(done_cnt - base), 8'd1);
        check_display(31);

        // Reset mid-conversion aborts without a done pulse
        base = done_cnt;
        drive_load(16);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_an", 8'(an), 8'(2'b11));
        chk("abort_seg", 8'(seg), 8'(7'b1111111));
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick();
        chk("abort_no_done", 8'(done_cnt - base), 8'd0);
        check_display(0);
        load_and_check(16);
        check_display(16);

        // Randomized values against the decimal model
        for (int k = 0; k < 8; k++) begin
            v = $urandom_range(0, 31);
            load_and_check(v);
            check_display(v);
        end

        // Free run: digit enable flips every DIV cycles and never shows both digits
        prev_an = an;
        run = 0;
        seen_change = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            run++;
            chk("free_an_not_00", 8'(an == 2'b00), 8'd0);
            if (an !== prev_an) begin
                if (seen_change) chk("free_period", 8'(run), 8'(DIV));
                seen_change = 1'b1;
                run = 0;
                prev_an = an;
            end
        end
        chk("free_toggled", 8'(seen_change), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
